spwm_ctrl: RTL and testbench
============================

SPWM_CTRL -- requirements
Module: spwm_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: data width of references and carrier.
REQ-002 SHALL have parameter Q, default 24: fractional bits; 1.0 = 2**Q.
REQ-003 SHALL have parameter REF_LIM, default 2**Q-1: symmetric clamp magnitude for references.
REQ-004 SHALL have parameter PEAK_TH, default 32'sh0FFFFFFF: carrier peak threshold.
REQ-005 SHALL have parameter VALLEY_TH, default 32'shF0000001: carrier valley threshold.
REQ-006 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- res  in  1  reset, synchronous, active-high.
- count  in  N signed  triangle carrier value.
- enable  in  1  run request.
- fault  in  1  hardware trip, level.
- fault_clr  in  1  fault acknowledge.
- ref_x/ref_y/ref_z  in  N signed  new phase references.
- ref_valid  in  1  references present.
- ref_ready  out  1  shadow buffer can accept.
- x_act/y_act/z_act  out  N signed  active references to the modulator.
- pwm_en  out  1  gate for switch outputs.
- sample_strobe  out  1  one-cycle pulse at carrier peak.
- update_strobe  out  1  one-cycle pulse when active references change.
- stale_cnt  out  8  saturating count of valleys with no new data.
- state  out  2  current FSM state.

Function
REQ-007 SHALL register a peak event on the first cycle where count >= PEAK_TH after a cycle where it was not; valley event likewise for count <= VALLEY_TH. Both are edge-detected and last one cycle.
REQ-008 SHALL implement FSM IDLE(0), ARM(1), RUN(2), FAULT(3).
REQ-009 IDLE SHALL go to ARM when enable=1.
REQ-010 ARM SHALL go to RUN on a valley event with shadow full. The shadow SHALL be committed in that cycle.
REQ-011 RUN SHALL go to IDLE on a valley event while enable=0. ARM SHALL go to IDLE immediately when enable=0.
REQ-012 Any state SHALL go to FAULT the cycle after fault=1 is sampled. Fault has priority over all other transitions.
REQ-013 FAULT SHALL go to IDLE when fault_clr=1 and fault=0.
REQ-014 Handshake: ref_ready = shadow empty AND state in {ARM, RUN}. A transfer occurs when ref_valid and ref_ready are both 1.
REQ-015 On a transfer, the block SHALL store each reference clamped to [-REF_LIM, +REF_LIM] into the one-entry shadow and mark it full.
REQ-016 On a valley event in ARM or RUN with shadow full, the block SHALL:
- copy the shadow to x/y/z_act on the next edge;
- clear full;
- pulse update_strobe in the same cycle the outputs change.
REQ-017 If ref_valid arrives on a valley cycle with shadow empty, the data SHALL be accepted but not committed until the next valley. There is no bypass path.
REQ-018 On a valley event in RUN with shadow empty, the block SHALL hold x/y/z_act and increment stale_cnt, saturating at 255.
REQ-019 sample_strobe SHALL pulse on peak events only in ARM and RUN.
REQ-020 pwm_en SHALL be 1 only in RUN. It SHALL be registered, rising with the committing edge and falling with the state exit.
REQ-021 Entering FAULT or IDLE SHALL zero x/y/z_act and clear the shadow. stale_cnt SHALL clear on entering ARM.
REQ-022 Simultaneous peak and valley events are impossible by threshold choice. If both occur, valley handling SHALL take precedence and no sample_strobe SHALL be issued.

Reset
REQ-023 When res=1 at a rising edge, the block SHALL enter IDLE and set every output to 0 (ref_ready=0, pwm_en=0, strobes=0, stale_cnt=0, x/y/z_act=0).
REQ-024 Reset SHALL clear the shadow and the event-detector history flags. Reset mid-operation SHALL abort without a final update.

Structure
REQ-025 A shared package SHALL hold the state encoding and the default PEAK_TH and VALLEY_TH constants.
REQ-026 Peak/valley edge detection SHALL be a sub-module carrier_evt (inputs clk, res, count; outputs peak, valley).

Verification
REQ-027 Bench SHALL check basic commit:
- stimulus: enable=1, ref_x=0x00400000 accepted in ARM, then valley;
- response: state=RUN, x_act=0x00400000, update_strobe=1 for one cycle, pwm_en=1.
REQ-028 Bench SHALL check clamping: ref_y=0x7FFFFFFF with Q=24 -> y_act=0x00FFFFFF after commit.
REQ-029 Bench SHALL check back-pressure: a second ref_valid before the valley -> ref_ready=0, the first value is committed, and the second is accepted the cycle after the commit.
REQ-030 Bench SHALL check stale counting: three valleys in RUN with no data -> stale_cnt=3 and x_act unchanged.
REQ-031 Bench SHALL check fault handling:
- fault=1 mid-RUN -> next cycle state=FAULT, pwm_en=0, x/y/z_act=0;
- fault_clr with fault=0 -> state=IDLE.
REQ-032 Bench SHALL check reset: res=1 in RUN with shadow full -> all outputs 0 next cycle, and no update_strobe at the following valley.

Source files
------------

// File: rtl/spwm_ctrl_pkg.sv
// Shared types and default thresholds for the SPWM reference controller.
package spwm_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StRun   = 2'd2,
        StFault = 2'd3
    } state_e;

    localparam logic signed [31:0] PeakThDef   = 32'sh0FFF_FFFF;
    localparam logic signed [31:0] ValleyThDef = 32'shF000_0001;

endpackage

// File: rtl/carrier_evt.sv
// Edge-detected peak/valley events from the triangle carrier; each lasts one cycle.
module carrier_evt #(
    parameter int unsigned            N         = 32,
    parameter logic signed [N-1:0]    PEAK_TH   = spwm_ctrl_pkg::PeakThDef,
    parameter logic signed [N-1:0]    VALLEY_TH = spwm_ctrl_pkg::ValleyThDef
) (
    input  logic                clk,
    input  logic                res,
    input  logic signed [N-1:0] count,
    output logic                peak,
    output logic                valley
);

    logic above, below;
    logic above_q, below_q;

    assign above  = (count >= PEAK_TH);
    assign below  = (count <= VALLEY_TH);
    assign peak   = above && !above_q;
    assign valley = below && !below_q;

    always_ff @(posedge clk) begin
        if (res) begin
            above_q <= 1'b0;
            below_q <= 1'b0;
        end else begin
            above_q <= above;
            below_q <= below;
        end
    end

endmodule

// File: rtl/spwm_ctrl.sv
// Three-phase SPWM reference controller: single-entry shadow buffer committed at carrier valleys.
module spwm_ctrl
    import spwm_ctrl_pkg::*;
#(
    parameter int unsigned         N         = 32,
    parameter int unsigned         Q         = 24,
    parameter int unsigned         REF_LIM   = 2**Q - 1,
    parameter logic signed [N-1:0] PEAK_TH   = PeakThDef,
    parameter logic signed [N-1:0] VALLEY_TH = ValleyThDef
) (
    input  logic                clk,
    input  logic                res,
    input  logic signed [N-1:0] count,
    input  logic                enable,
    input  logic                fault,
    input  logic                fault_clr,
    input  logic signed [N-1:0] ref_x,
    input  logic signed [N-1:0] ref_y,
    input  logic signed [N-1:0] ref_z,
    input  logic                ref_valid,
    output logic                ref_ready,
    output logic signed [N-1:0] x_act,
    output logic signed [N-1:0] y_act,
    output logic signed [N-1:0] z_act,
    output logic                pwm_en,
    output logic                sample_strobe,
    output logic                update_strobe,
    output logic [7:0]          stale_cnt,
    output logic [1:0]          state
);

    localparam logic signed [N-1:0] LimP = N'(REF_LIM);
    localparam logic signed [N-1:0] LimN = -LimP;

    function automatic logic signed [N-1:0] clamp(input logic signed [N-1:0] v);
        if (v > LimP) return LimP;
        if (v < LimN) return LimN;
        return v;
    endfunction

    logic peak, valley;

    carrier_evt #(
        .N         (N),
        .PEAK_TH   (PEAK_TH),
        .VALLEY_TH (VALLEY_TH)
    ) u_evt (
        .clk    (clk),
        .res    (res),
        .count  (count),
        .peak   (peak),
        .valley (valley)
    );

    state_e state_q, state_d;

    logic                full_q, full_d;
    logic signed [N-1:0] sh_x_q, sh_y_q, sh_z_q;
    logic signed [N-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
    logic                pwm_q, pwm_d, upd_q, upd_d, smp_q, smp_d;
    logic [7:0]          stale_q, stale_d;
    logic                active, xfer, commit, zero_out;

    always_ff @(posedge clk) begin
        if (res) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Fault overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StIdle:  if (enable) state_d = StArm;
                StArm: begin
                    if (!enable)              state_d = StIdle;
                    else if (valley && full_q) state_d = StRun;
                end
                StRun:   if (valley && !enable) state_d = StIdle;
                StFault: if (fault_clr) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        active   = (state_q == StArm) || (state_q == StRun);
        ref_ready = !full_q && active;
        xfer     = ref_valid && ref_ready;
        commit   = valley && full_q && (state_d == StRun);
        zero_out = (state_d == StIdle) || (state_d == StFault);

        full_d = full_q;
        if (zero_out || commit) full_d = 1'b0;
        else if (xfer)          full_d = 1'b1;

        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (zero_out) begin
            x_d = '0;
            y_d = '0;
            z_d = '0;
        end else if (commit) begin
            x_d = sh_x_q;
            y_d = sh_y_q;
            z_d = sh_z_q;
        end

        stale_d = stale_q;
        if (state_q != StArm && state_d == StArm) begin
            stale_d = '0;
        end else if (state_q == StRun && state_d == StRun && valley && !full_q
                     && stale_q != 8'hFF) begin
            stale_d = stale_q + 8'd1;
        end

        upd_d = commit;
        smp_d = peak && !valley && active && !fault;
        pwm_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            full_q  <= 1'b0;
            sh_x_q  <= '0;
            sh_y_q  <= '0;
            sh_z_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            pwm_q   <= 1'b0;
            upd_q   <= 1'b0;
            smp_q   <= 1'b0;
            stale_q <= '0;
        end else begin
            full_q <= full_d;
            if (xfer) begin
                sh_x_q <= clamp(ref_x);
                sh_y_q <= clamp(ref_y);
                sh_z_q <= clamp(ref_z);
            end
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            pwm_q   <= pwm_d;
            upd_q   <= upd_d;
            smp_q   <= smp_d;
            stale_q <= stale_d;
        end
    end

    assign x_act         = x_q;
    assign y_act         = y_q;
    assign z_act         = z_q;
    assign pwm_en        = pwm_q;
    assign update_strobe = upd_q;
    assign sample_strobe = smp_q;
    assign stale_cnt     = stale_q;
    assign state         = state_q;

endmodule

// File: tb/tb_spwm_ctrl.sv
// Directed self-checking bench for spwm_ctrl with default parameters.
module tb_spwm_ctrl;

    localparam logic signed [31:0] CMid = 32'sh0000_0000;
    localparam logic signed [31:0] CHi  = 32'sh1000_0000;
    localparam logic signed [31:0] CLo  = 32'shF000_0000;

    logic               clk = 1'b0;
    logic               res = 1'b0;
    logic signed [31:0] count = CMid;
    logic               enable = 1'b0, fault = 1'b0, fault_clr = 1'b0;
    logic signed [31:0] ref_x = '0, ref_y = '0, ref_z = '0;
    logic               ref_valid = 1'b0;
    logic               ref_ready, pwm_en, sample_strobe, update_strobe;
    logic signed [31:0] x_act, y_act, z_act;
    logic [7:0]         stale_cnt;
    logic [1:0]         state;

    int checks = 0;
    int failures = 0;

    spwm_ctrl dut (
        .clk           (clk),
        .res           (res),
        .count         (count),
        .enable        (enable),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .ref_x         (ref_x),
        .ref_y         (ref_y),
        .ref_z         (ref_z),
        .ref_valid     (ref_valid),
        .ref_ready     (ref_ready),
        .x_act         (x_act),
        .y_act         (y_act),
        .z_act         (z_act),
        .pwm_en        (pwm_en),
        .sample_strobe (sample_strobe),
        .update_strobe (update_strobe),
        .stale_cnt     (stale_cnt),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            failures++; $display("FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if ({ref_ready, pwm_en, sample_strobe, update_strobe} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got %b want 0000",
                     {ref_ready, pwm_en, sample_strobe, update_strobe});
        end
        checks++;
        if ({x_act, y_act, z_act, stale_cnt} !== 104'd0) begin
            failures++;
            $display("FAIL reset_data got %h %h %h %0d want zeros", x_act, y_act, z_act, stale_cnt);
        end
    endtask

    task automatic test_commit();
        enable = 1'b1;
        tick();
        checks++;
        if (state !== 2'd1 || ref_ready !== 1'b1) begin
            failures++; $display("FAIL arm_entry got st=%0d rdy=%b want st=1 rdy=1", state, ref_ready);
        end
        ref_valid = 1'b1;
        ref_x = 32'sh0040_0000;
        ref_y = 32'sh7FFF_FFFF;
        ref_z = 32'sh8000_0001;
        tick();
        ref_valid = 1'b0;
        checks++;
        if (ref_ready !== 1'b0 || state !== 2'd1 || pwm_en !== 1'b0) begin
            failures++;
            $display("FAIL arm_full got rdy=%b st=%0d pwm=%b want 0 1 0", ref_ready, state, pwm_en);
        end
        count = CLo;
        tick();
        count = CMid;
        checks++;
        if (state !== 2'd2 || pwm_en !== 1'b1 || update_strobe !== 1'b1) begin
            failures++;
            $display("FAIL commit_ctrl got st=%0d pwm=%b upd=%b want 2 1 1", state, pwm_en, update_strobe);
        end
        checks++;
        if (x_act !== 32'sh0040_0000) begin
            failures++; $display("FAIL commit_x got %h want 00400000", x_act);
        end
        checks++;
        if (y_act !== 32'sh00FF_FFFF) begin
            failures++; $display("FAIL clamp_pos got %h want 00ffffff", y_act);
        end
        checks++;
        if (z_act !== 32'shFF00_0001) begin
            failures++; $display("FAIL clamp_neg got %h want ff000001", z_act);
        end
        tick();
        checks++;
        if (update_strobe !== 1'b0 || pwm_en !== 1'b1 || x_act !== 32'sh0040_0000) begin
            failures++;
            $display("FAIL commit_after got upd=%b pwm=%b x=%h want 0 1 00400000",
                     update_strobe, pwm_en, x_act);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (ref_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready0 got %b want 1", ref_ready);
        end
        ref_valid = 1'b1;
        ref_x = 32'sh0010_0000;
        tick();
        ref_x = 32'sh0020_0000;
        checks++;
        if (ref_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_backpressure got %b want 0", ref_ready);
        end
        tick();
        count = CLo;
        tick();
        count = CMid;
        checks++;
        if (x_act !== 32'sh0010_0000 || update_strobe !== 1'b1 || ref_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got x=%h upd=%b rdy=%b want 00100000 1 1",
                     x_act, update_strobe, ref_ready);
        end
        tick();
        ref_valid = 1'b0;
        checks++;
        if (ref_ready !== 1'b0 || x_act !== 32'sh0010_0000) begin
            failures++;
            $display("FAIL b2b_second_accept got rdy=%b x=%h want 0 00100000", ref_ready, x_act);
        end
        count = CLo;
        tick();
        count = CMid;
        tick();
        checks++;
        if (x_act !== 32'sh0020_0000) begin
            failures++; $display("FAIL b2b_second_commit got %h want 00200000", x_act);
        end
    endtask

    task automatic test_stale();
        int upd_seen = 0;
        checks++;
        if (stale_cnt !== 8'd0) begin
            failures++; $display("FAIL stale_start got %0d want 0", stale_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            count = CLo;
            tick();
            if (update_strobe) upd_seen++;
            count = CMid;
            tick();
        end
        checks++;
        if (stale_cnt !== 8'd3) begin
            failures++; $display("FAIL stale_count got %0d want 3", stale_cnt);
        end
        checks++;
        if (x_act !== 32'sh0020_0000 || upd_seen != 0 || state !== 2'd2) begin
            failures++;
            $display("FAIL stale_hold got x=%h upd=%0d st=%0d want 00200000 0 2", x_act, upd_seen, state);
        end
    endtask

    task automatic test_peak();
        count = CHi;
        tick();
        checks++;
        if (sample_strobe !== 1'b1) begin
            failures++; $display("FAIL peak_pulse got %b want 1", sample_strobe);
        end
        tick();
        checks++;
        if (sample_strobe !== 1'b0) begin
            failures++; $display("FAIL peak_edge_only got %b want 0", sample_strobe);
        end
        count = CMid;
        tick();
    endtask

    task automatic test_fault();
        fault = 1'b1;
        tick();
        fault = 1'b0;
        checks++;
        if (state !== 2'd3 || pwm_en !== 1'b0 || ref_ready !== 1'b0) begin
            failures++;
            $display("FAIL fault_entry got st=%0d pwm=%b rdy=%b want 3 0 0", state, pwm_en, ref_ready);
        end
        checks++;
        if ({x_act, y_act, z_act} !== 96'd0) begin
            failures++; $display("FAIL fault_zero got %h %h %h want zeros", x_act, y_act, z_act);
        end
        tick();
        checks++;
        if (state !== 2'd3) begin
            failures++; $display("FAIL fault_hold got %0d want 3", state);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            failures++; $display("FAIL fault_clear got %0d want 0", state);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        checks++;
        if (state !== 2'd1 || stale_cnt !== 8'd0) begin
            failures++; $display("FAIL rearm got st=%0d stale=%0d want 1 0", state, stale_cnt);
        end
        ref_valid = 1'b1;
        ref_x = 32'sh0030_0000;
        tick();
        ref_valid = 1'b0;
        count = CLo;
        tick();
        count = CMid;
        tick();
        ref_valid = 1'b1;
        ref_x = 32'sh0050_0000;
        tick();
        ref_valid = 1'b0;
        checks++;
        if (state !== 2'd2 || x_act !== 32'sh0030_0000 || ref_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset got st=%0d x=%h rdy=%b want 2 00300000 0", state, x_act, ref_ready);
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        checks++;
        if ({state, ref_ready, pwm_en, sample_strobe, update_strobe} !== 6'd0
            || {x_act, y_act, z_act, stale_cnt} !== 104'd0) begin
            failures++;
            $display("FAIL mid_reset got st=%0d rdy=%b pwm=%b x=%h want all zero",
                     state, ref_ready, pwm_en, x_act);
        end
        count = CLo;
        tick();
        count = CMid;
        checks++;
        if (update_strobe !== 1'b0 || x_act !== 32'sh0 || state !== 2'd1) begin
            failures++;
            $display("FAIL post_reset_valley got upd=%b x=%h st=%0d want 0 0 1",
                     update_strobe, x_act, state);
        end
    endtask

    task automatic test_arm_exit();
        enable = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || ref_ready !== 1'b0) begin
            failures++; $display("FAIL arm_exit got st=%0d rdy=%b want 0 0", state, ref_ready);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_back_to_back();
        test_stale();
        test_peak();
        test_fault();
        test_reset_mid();
        test_arm_exit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
